// File: rtl/nios_project_13_nios2_qsys_0_oci_dct_sequencer.sv
// ---------------------------------------------------------------------------
// nios_project_13_nios2_qsys_0_oci_dct_sequencer
//
// Purpose:
//   Sequences the OCI direct-branch compression trace (DCT) datapath.
//   - Packs 2-bit direct-branch codes into a 30-bit buffer (newest in [1:0])
//     and emits full or partial DCT frames {2'b01, count, buffer}.
//   - Interleaves indirect-branch records {2'b10, 2'b00, addr} with DCT
//     frames on one 36-bit trace-word output, keeping program order.
//   - Drains everything on test_ending and then raises test_has_ended.
//
// Ports:
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   dct_valid/code/ready    direct-branch code input handshake
//   itrace_valid/addr/ready indirect-branch record input handshake
//   tw_valid/data/ready     36-bit trace-word output handshake
//   test_ending             request to stop accepting and drain (sticky)
//   dct_buffer, dct_count   current packed codes and how many are held
//   test_has_ended          sticky: drain complete
//
// Parameters:
//   DCT_DEPTH       max codes per DCT frame (1..15)
//   TIMEOUT_CYCLES  idle cycles before a forced partial flush
//
// Build option:
//   DCT_TIMEOUT_EN  when defined, a partially filled buffer that sits idle
//                   for TIMEOUT_CYCLES cycles is flushed as a partial frame.
//                   When undefined, partial frames only come from indirect
//                   records or from ending.
// ---------------------------------------------------------------------------
module nios_project_13_nios2_qsys_0_oci_dct_sequencer #(
    parameter int unsigned DCT_DEPTH      = 15,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dct_valid,
    input  logic [1:0]  dct_code,
    output logic        dct_ready,
    input  logic        itrace_valid,
    input  logic [31:0] itrace_addr,
    output logic        itrace_ready,
    output logic        tw_valid,
    output logic [35:0] tw_data,
    input  logic        tw_ready,
    input  logic        test_ending,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        test_has_ended
);

    localparam logic [3:0] DEPTH = 4'(DCT_DEPTH);

    // Elaboration-time guards on the parameter ranges the packing relies on.
    if (DCT_DEPTH < 1 || DCT_DEPTH > 15) begin : g_bad_depth
        $error("DCT_DEPTH must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic        ending;
    logic        ind_pending;
    logic [31:0] ind_addr;
    logic        ended_q;
    logic        slot_free;
    logic        buffer_full;
    logic        dct_load;
    logic        ind_load;
    logic        code_accept;
    logic        ind_accept;
    logic        timeout;
    logic        drained;

    // A frame may be loaded whenever the output register is empty or is being
    // consumed this cycle. DCT frames take priority over the pending indirect
    // record: any codes still buffered were captured before that record, so
    // they must go out first. The indirect record only loads once the buffer
    // is empty.
    assign slot_free   = !tw_valid || tw_ready;
    assign buffer_full = (dct_count == DEPTH);
    assign dct_load    = slot_free &&
                         (buffer_full ||
                          ((ind_pending || ending || timeout) && (dct_count != 4'd0)));
    assign ind_load    = slot_free && !dct_load && ind_pending && (dct_count == 4'd0);

    // A full buffer can still take a code in the cycle it is flushed, because
    // the new code lands in the emptied buffer. Codes stall behind a pending
    // indirect record so they cannot overtake it.
    assign dct_ready    = !ending && !ind_pending && ((dct_count < DEPTH) || dct_load);
    assign itrace_ready = !ending && !ind_pending;
    assign code_accept  = dct_valid && dct_ready;
    assign ind_accept   = itrace_valid && itrace_ready;

    // Drain is complete when nothing is held anywhere. The combinational term
    // lets test_has_ended rise in the very cycle this becomes true; the
    // register keeps it sticky afterwards.
    assign drained        = ending && (dct_count == 4'd0) && !ind_pending && !tw_valid;
    assign test_has_ended = ended_q || drained;

`ifdef DCT_TIMEOUT_EN
    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Counts idle cycles of a non-empty buffer. The cycle in which the counter
    // sits at its last value is the TIMEOUT_CYCLES-th idle cycle, so the flush
    // loads on that cycle's closing edge. The counter saturates there so the
    // timeout stays asserted while the output is blocked.
    assign timeout = (dct_count != 4'd0) && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (code_accept || dct_load) begin
            idle_cnt <= '0;
        end else if ((dct_count != 4'd0) && (idle_cnt != IDLE_LAST)) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Code buffer and count. A flush and an accept in the same cycle leave
    // exactly the new code in the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= 4'd0;
        end else if (dct_load) begin
            dct_buffer <= code_accept ? {28'b0, dct_code} : 30'b0;
            dct_count  <= code_accept ? 4'd1 : 4'd0;
        end else if (code_accept) begin
            dct_buffer <= {dct_buffer[27:0], dct_code};
            dct_count  <= dct_count + 4'd1;
        end
    end

    // Single-entry holding register for the indirect-branch record. Accept and
    // load are mutually exclusive because accept requires !ind_pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ind_pending <= 1'b0;
            ind_addr    <= '0;
        end else if (ind_accept) begin
            ind_pending <= 1'b1;
            ind_addr    <= itrace_addr;
        end else if (ind_load) begin
            ind_pending <= 1'b0;
        end
    end

    // Output trace-word register. tw_data only changes on a load, and a load
    // only happens when the slot is free, so the word holds steady while the
    // consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tw_valid <= 1'b0;
            tw_data  <= '0;
        end else if (dct_load) begin
            tw_valid <= 1'b1;
            tw_data  <= {2'b01, dct_count, dct_buffer};
        end else if (ind_load) begin
            tw_valid <= 1'b1;
            tw_data  <= {2'b10, 2'b00, ind_addr};
        end else if (tw_ready) begin
            tw_valid <= 1'b0;
        end
    end

    // Sticky end-of-test state: ending blocks new input from the next cycle
    // on, ended_q remembers that the drain completed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ending  <= 1'b0;
            ended_q <= 1'b0;
        end else begin
            ending  <= ending || test_ending;
            ended_q <= ended_q || drained;
        end
    end

endmodule

// File: tb/tb_nios_project_13_nios2_qsys_0_oci_dct_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_nios_project_13_nios2_qsys_0_oci_dct_sequencer
//
// Directed bench with a frame scoreboard: stimulus pushes hand-computed
// trace words into a queue, a monitor pops and compares on every output
// handshake. Direct checks cover reset values, stalls and end-of-test flags.
// ---------------------------------------------------------------------------
module tb_nios_project_13_nios2_qsys_0_oci_dct_sequencer;

    logic        clk;
    logic        reset_n;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        dct_ready;
    logic        itrace_valid;
    logic [31:0] itrace_addr;
    logic        itrace_ready;
    logic        tw_valid;
    logic [35:0] tw_data;
    logic        tw_ready;
    logic        test_ending;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_has_ended;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];

    nios_project_13_nios2_qsys_0_oci_dct_sequencer #(
        .DCT_DEPTH      (15),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dct_valid      (dct_valid),
        .dct_code       (dct_code),
        .dct_ready      (dct_ready),
        .itrace_valid   (itrace_valid),
        .itrace_addr    (itrace_addr),
        .itrace_ready   (itrace_ready),
        .tw_valid       (tw_valid),
        .tw_data        (tw_data),
        .tw_ready       (tw_ready),
        .test_ending    (test_ending),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_has_ended (test_has_ended)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case some wait is never satisfied.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every accepted trace word must match the oldest
    // expected frame.
    initial begin
        logic [35:0] exp_word;
        forever begin
            @(negedge clk);
            if (reset_n && tw_valid && tw_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_frame: got 0x%0h, expected no frame", tw_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    checkOutput("frame", {28'b0, tw_data}, {28'b0, exp_word});
                end
            end
        end
    end

    // Offers one code and holds it until accepted; returns 1ns after the
    // accepting edge.
    task automatic applyStimulus(input logic [1:0] code);
        int n = 0;
        dct_valid = 1'b1;
        dct_code  = code;
        @(negedge clk);
        while (!dct_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!dct_ready) checkOutput("code_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        dct_valid = 1'b0;
    endtask

    task automatic sendIndirect(input logic [31:0] addr);
        int n = 0;
        itrace_valid = 1'b1;
        itrace_addr  = addr;
        @(negedge clk);
        while (!itrace_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!itrace_ready) checkOutput("indirect_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        itrace_valid = 1'b0;
    endtask

    task automatic pulseEnding();
        test_ending = 1'b1;
        @(posedge clk);
        #1;
        test_ending = 1'b0;
    endtask

    // Leaves the bench at a negedge where a handshake is being presented.
    task automatic waitHandshake(input string name);
        int n = 0;
        @(negedge clk);
        while (!(tw_valid && tw_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(tw_valid && tw_ready)) checkOutput(name, 64'd0, 64'd1);
    endtask

    task automatic doReset();
        checkOutput("frames_outstanding", 64'(exp_q.size()), 64'd0);
        reset_n      = 1'b0;
        dct_valid    = 1'b0;
        itrace_valid = 1'b0;
        test_ending  = 1'b0;
        tw_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b0;
        dct_valid    = 1'b0;
        dct_code     = 2'b00;
        itrace_valid = 1'b0;
        itrace_addr  = 32'h0;
        tw_ready     = 1'b1;
        test_ending  = 1'b0;

        // Reset values, visible before any clock edge.
        #3;
        checkOutput("rst_tw_valid", 64'(tw_valid), 64'd0);
        checkOutput("rst_tw_data", 64'(tw_data), 64'd0);
        checkOutput("rst_count", 64'(dct_count), 64'd0);
        checkOutput("rst_buffer", 64'(dct_buffer), 64'd0);
        checkOutput("rst_has_ended", 64'(test_has_ended), 64'd0);
        checkOutput("rst_dct_ready", 64'(dct_ready), 64'd1);
        checkOutput("rst_itrace_ready", 64'(itrace_ready), 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Full frame of 15 taken codes.
        $display("[TB] full frame");
        exp_q.push_back({2'b01, 4'd15, 30'h15555555});
        for (int i = 0; i < 15; i++) applyStimulus(2'b01);
        checkOutput("full_count_15", 64'(dct_count), 64'd15);
        checkOutput("full_not_yet_valid", 64'(tw_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("full_valid_next", 64'(tw_valid), 64'd1);
        checkOutput("full_count_cleared", 64'(dct_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // Partial frame ahead of an indirect record; codes stall meanwhile.
        $display("[TB] partial frame then indirect");
        exp_q.push_back({2'b01, 4'd3, 30'h19});
        exp_q.push_back({2'b10, 2'b00, 32'h0000_1234});
        applyStimulus(2'b01);
        applyStimulus(2'b10);
        applyStimulus(2'b01);
        sendIndirect(32'h0000_1234);
        dct_valid = 1'b1;
        dct_code  = 2'b01;
        @(negedge clk);
        checkOutput("stall_behind_indirect_a", 64'(dct_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("stall_behind_indirect_b", 64'(dct_ready), 64'd0);
        checkOutput("dct_frame_first", 64'(tw_data[35:34]), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("ready_after_indirect", 64'(dct_ready), 64'd1);
        @(posedge clk);
        #1;
        dct_valid = 1'b0;
        checkOutput("stalled_code_count", 64'(dct_count), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        doReset();

        // Blocked output: one frame stuck in the output, buffer refills, the
        // 31st code stalls until the consumer resumes.
        $display("[TB] blocked output");
        tw_ready = 1'b0;
        exp_q.push_back({2'b01, 4'd15, 30'h2AAAAAAA});
        exp_q.push_back({2'b01, 4'd15, 30'h15555555});
        for (int i = 0; i < 15; i++) applyStimulus(2'b10);
        for (int i = 0; i < 15; i++) applyStimulus(2'b01);
        checkOutput("blocked_count_full", 64'(dct_count), 64'd15);
        fork
            applyStimulus(2'b11);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checkOutput("blocked_dct_ready", 64'(dct_ready), 64'd0);
                    checkOutput("blocked_tw_data", 64'(tw_data), 64'({2'b01, 4'd15, 30'h2AAAAAAA}));
                end
                @(posedge clk);
                #1;
                tw_ready = 1'b1;
            end
        join
        checkOutput("unblocked_count", 64'(dct_count), 64'd1);
        checkOutput("unblocked_buffer", 64'(dct_buffer), 64'h3);
        repeat (3) @(posedge clk);
        #1;
        doReset();

        // Ending drains a partial frame and then blocks input.
        $display("[TB] ending drain");
        exp_q.push_back({2'b01, 4'd5, 30'h16B});
        applyStimulus(2'b01);
        applyStimulus(2'b01);
        applyStimulus(2'b10);
        applyStimulus(2'b10);
        applyStimulus(2'b11);
        test_ending = 1'b1;
        @(negedge clk);
        checkOutput("ready_same_cycle_as_ending", 64'(dct_ready), 64'd1);
        @(posedge clk);
        #1;
        test_ending = 1'b0;
        dct_valid   = 1'b1;
        dct_code    = 2'b01;
        @(negedge clk);
        checkOutput("ending_dct_ready", 64'(dct_ready), 64'd0);
        checkOutput("ending_itrace_ready", 64'(itrace_ready), 64'd0);
        checkOutput("not_ended_before_frame", 64'(test_has_ended), 64'd0);
        waitHandshake("ending_frame_timeout");
        checkOutput("not_ended_at_handshake", 64'(test_has_ended), 64'd0);
        @(negedge clk);
        checkOutput("ended_after_handshake", 64'(test_has_ended), 64'd1);
        repeat (4) @(negedge clk);
        checkOutput("ended_sticky", 64'(test_has_ended), 64'd1);
        checkOutput("ignored_after_ending", 64'(dct_count), 64'd0);
        dct_valid = 1'b0;
        doReset();
        checkOutput("reset_clears_ending", 64'(dct_ready), 64'd1);

        // Reset in the middle of collection with a frame held at the output.
        $display("[TB] mid-frame reset");
        tw_ready = 1'b0;
        for (int i = 0; i < 15; i++) applyStimulus(2'b01);
        for (int i = 0; i < 7; i++) applyStimulus(2'b10);
        checkOutput("pre_reset_count", 64'(dct_count), 64'd7);
        checkOutput("pre_reset_valid", 64'(tw_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 64'(tw_valid), 64'd0);
        checkOutput("async_rst_data", 64'(tw_data), 64'd0);
        checkOutput("async_rst_count", 64'(dct_count), 64'd0);
        checkOutput("async_rst_buffer", 64'(dct_buffer), 64'd0);
        tw_ready = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.push_back({2'b01, 4'd2, 30'h9});
        applyStimulus(2'b10);
        applyStimulus(2'b01);
        pulseEnding();
        waitHandshake("post_reset_frame_timeout");
        @(negedge clk);
        checkOutput("post_reset_ended", 64'(test_has_ended), 64'd1);
        doReset();

        // Idle partial buffer.
        $display("[TB] idle partial buffer");
        applyStimulus(2'b01);
        applyStimulus(2'b11);
`ifdef DCT_TIMEOUT_EN
        exp_q.push_back({2'b01, 4'd2, 30'h7});
        repeat (63) @(posedge clk);
        #1;
        checkOutput("timeout_not_early", 64'(tw_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("timeout_frame_valid", 64'(tw_valid), 64'd1);
        repeat (2) @(posedge clk);
        #1;
`else
        begin
            logic saw_frame = 1'b0;
            repeat (100) begin
                @(negedge clk);
                if (tw_valid) saw_frame = 1'b1;
            end
            checkOutput("no_timeout_frame", 64'(saw_frame), 64'd0);
        end
        checkOutput("idle_count_held", 64'(dct_count), 64'd2);
        exp_q.push_back({2'b01, 4'd2, 30'h7});
        pulseEnding();
        waitHandshake("idle_drain_timeout");
        @(negedge clk);
`endif

        checkOutput("frames_outstanding_end", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
